// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master port among NUM_REQ requesters, one burst at a time.
// Optional macro AXI_RD_ARB_RLAST_CHECK_EN enables the registered s_rlast vs. beat-count error pulse.
module axi_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_arvalid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_REQ*8-1:0]          req_arlen,
    input  logic [NUM_REQ*3-1:0]          req_arsize,
    input  logic [NUM_REQ*2-1:0]          req_arburst,
    output logic [NUM_REQ-1:0]            req_arready,
    output logic [NUM_REQ-1:0]            req_rvalid,
    input  logic [NUM_REQ-1:0]            req_rready,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic                          req_rlast,
    output logic                          m_arvalid,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic [7:0]                    m_arlen,
    output logic [2:0]                    m_arsize,
    output logic [1:0]                    m_arburst,
    input  logic                          s_arready,
    input  logic                          s_rvalid,
    input  logic [DATA_WIDTH-1:0]         s_rdata,
    input  logic                          s_rlast,
    output logic                          m_rready,
    output logic                          busy,
    output logic [ID_W-1:0]               grant_id,
    output logic                          err_rlast
);

    typedef enum logic [1:0] {ARBITRATE, ISSUE_ADDRESS, ACTIVE_BURST} state_t;

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    state_t                  state, state_next;
    logic [ID_W-1:0]         rr_ptr;
    logic [ID_W-1:0]         win_off;
    logic [ID_W-1:0]         winner;
    logic                    found;
    logic [2*NUM_REQ-1:0]    rot;
    logic [ID_W:0]           win_sum;
    logic [ID_W:0]           ptr_sum;
    logic [NUM_REQ-1:0]      grant_oh;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [7:0]              sel_len;
    logic [2:0]              sel_size;
    logic [1:0]              sel_burst;
    logic [7:0]              beat_cnt;
    logic                    r_hs;

    // Rotate the request vector so bit 0 is rr_ptr, take the first set bit, then un-rotate.
    always_comb begin
        rot     = {req_arvalid, req_arvalid} >> rr_ptr;
        found   = 1'b0;
        win_off = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found   = 1'b1;
                win_off = ID_W'(i);
            end
        end
        win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
        if (win_sum >= NUM_REQ_W)
            win_sum = win_sum - NUM_REQ_W;
        winner = win_sum[ID_W-1:0];
    end

    always_comb begin
        sel_addr  = '0;
        sel_len   = '0;
        sel_size  = '0;
        sel_burst = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == winner) begin
                sel_addr  = req_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len   = req_arlen[i*8 +: 8];
                sel_size  = req_arsize[i*3 +: 3];
                sel_burst = req_arburst[i*2 +: 2];
            end
        end
    end

    always_comb begin
        ptr_sum = {1'b0, grant_id} + (ID_W+1)'(1);
        if (ptr_sum >= NUM_REQ_W)
            ptr_sum = '0;
    end

    assign grant_oh  = NUM_REQ'(1) << grant_id;
    assign req_rdata = s_rdata;
    assign busy      = (state != ARBITRATE);
    assign r_hs      = (state == ACTIVE_BURST) && s_rvalid && m_rready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ARBITRATE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        m_arvalid   = 1'b0;
        req_arready = '0;
        req_rvalid  = '0;
        m_rready    = 1'b0;
        req_rlast   = 1'b0;
        case (state)
            ARBITRATE: begin
                if (|req_arvalid)
                    state_next = ISSUE_ADDRESS;
            end
            ISSUE_ADDRESS: begin
                m_arvalid   = 1'b1;
                req_arready = s_arready ? grant_oh : '0;
                if (s_arready)
                    state_next = ACTIVE_BURST;
            end
            ACTIVE_BURST: begin
                req_rvalid = s_rvalid ? grant_oh : '0;
                m_rready   = |(req_rready & grant_oh);
                req_rlast  = s_rlast;
                if (s_rvalid && m_rready && (beat_cnt == 8'd0))
                    state_next = ARBITRATE;
            end
            default: state_next = ARBITRATE;
        endcase
    end

    // Burst end is decided by the beat counter alone; s_rlast is never trusted for control.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            grant_id  <= '0;
            beat_cnt  <= '0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arsize  <= '0;
            m_arburst <= '0;
        end else begin
            if (state == ARBITRATE && found) begin
                grant_id  <= winner;
                beat_cnt  <= sel_len;
                m_araddr  <= sel_addr;
                m_arlen   <= sel_len;
                m_arsize  <= sel_size;
                m_arburst <= sel_burst;
            end
            if (state == ISSUE_ADDRESS && s_arready)
                rr_ptr <= ptr_sum[ID_W-1:0];
            if (r_hs && beat_cnt != 8'd0)
                beat_cnt <= beat_cnt - 8'd1;
        end
    end

`ifdef AXI_RD_ARB_RLAST_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_rlast <= 1'b0;
        else
            err_rlast <= r_hs && (s_rlast != (beat_cnt == 8'd0));
    end
`else
    assign err_rlast = 1'b0;
`endif

endmodule
